led_frame_buffer: RTL and testbench
===================================

LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

Parameters
REQ-001 The block SHALL take parameter NUM_LEDS, default 6, meaning the number of LEDs in the chain.
REQ-002 The block SHALL take localparam AW = ceil(log2(NUM_LEDS)), minimum 1, as the width of every address.

Interface
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_valid  in  1  host pixel write request.
REQ-006 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-007 wr_addr  in  AW  LED index to write.
REQ-008 wr_red / wr_green / wr_blue  in  8 each  pixel colour to write.
REQ-009 commit  in  1  single-cycle pulse requesting a back/front bank swap.
REQ-010 commit_pending  out  1  swap requested, not yet taken.
REQ-011 wr_error  out  1  sticky flag: an out-of-range write occurred.
REQ-012 frame_start  out  1  one-cycle pulse on the cycle a frame read begins.
REQ-013 data_request  in  1  from the LED driver; pixel data is sampled on the following cycle.
REQ-014 address  in  AW  from the LED driver; index of the LED being requested.
REQ-015 red_out / green_out / blue_out  out  8 each  registered pixel data to the driver's red_in/green_in/blue_in.

Function
REQ-016 Storage SHALL be two banks, each NUM_LEDS x 24 bits; front bank index fsel, back bank = ~fsel.
REQ-017 The FSM SHALL have states CLEAR, IDLE and PENDING.
REQ-018 CLEAR SHALL write zero to address k of both banks at cycle k, for k = 0..NUM_LEDS-1, then go to IDLE.
REQ-019 wr_ready SHALL be 1 only in IDLE.
REQ-020 An accepted write with wr_addr < NUM_LEDS SHALL update the back bank at wr_addr on that edge.
REQ-021 An accepted write with wr_addr >= NUM_LEDS SHALL be dropped and SHALL set wr_error, which clears only on reset.
REQ-022 In IDLE, commit SHALL move the FSM to PENDING; a write accepted in the same cycle SHALL complete first.
REQ-023 commit outside IDLE SHALL be ignored.
REQ-024 commit_pending SHALL be 1 exactly while in PENDING.
REQ-025 frame_start SHALL pulse on any cycle with data_request=1 and address=0.
REQ-026 In PENDING, the cycle with data_request=1 and address=0 SHALL toggle fsel, return the FSM to IDLE, and be served from the new front bank.
REQ-027 On data_request=1, red/green/blue_out SHALL register front[address] at that edge (1-cycle latency) and hold until the next data_request.
REQ-028 The read data SHALL be zeros if address >= NUM_LEDS or the FSM is in CLEAR.
REQ-029 A swap SHALL NOT copy banks; the host writes every LED of the back bank before each commit.
REQ-030 Write and read ports SHALL be independent, so a simultaneous write and read never stall or corrupt each other.

Reset
REQ-031 Reset SHALL force state=CLEAR, fsel=0, red/green/blue_out=0, wr_ready=0, commit_pending=0, wr_error=0 and frame_start=0.
REQ-032 Reset asserted mid-operation (PENDING or mid-CLEAR) SHALL discard the pending swap and restart CLEAR from address 0.
REQ-033 After reset deasserts, wr_ready SHALL rise exactly NUM_LEDS cycles later.

Structure
REQ-034 A shared package SHALL hold the state encoding, the log2 function, and the pixel width constant (24).
REQ-035 One sub-module, led_bank_ram (one write port, one registered read port, parameterised depth), SHALL be instantiated twice, or once with the bank bit as the address MSB.

Verification
REQ-036 Reset, NUM_LEDS=6 -> wr_ready rises 6 cycles after reset deasserts; then data_request at address 0..5 returns 0x000000 for every LED.
REQ-037 Write LED2=(R,G,B)=(0x11,0x22,0x33), commit, then data_request with address=0 -> swap on that cycle; data_request at address 2 -> outputs 0x11/0x22/0x33 one cycle later.
REQ-038 commit while data_request=1 with address=3 -> no swap, commit_pending=1, wr_ready=0; swap occurs at the next address=0 request.
REQ-039 Write to wr_addr=7 with NUM_LEDS=6 -> wr_error=1, no bank change; the flag persists until reset.
REQ-040 Assert reset while PENDING -> fsel=0, pending cleared, CLEAR restarts, and all outputs return to 0.
REQ-041 Same-cycle wr_valid to LED5 and commit -> the LED5 value appears in the next frame after the swap.

Source files
------------

// File: rtl/led_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_frame_buffer_pkg
//  Description : Shared types and constants for the double-buffered LED frame
//                store (state encoding, pixel width, address-width helper).
//  Revision    : 1.0
// ============================================================================
package led_frame_buffer_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // ceil(log2(n)) with a floor of one bit so a single-LED chain still has an address
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : led_bank_ram
//  Description : One pixel bank: single write port, registered read port.
//  Revision    : 1.0
// ============================================================================
module led_bank_ram #(
    parameter int DEPTH = 6,
    parameter int AW    = 3,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];

    logic w_wr_in_range;
    logic w_rd_in_range;

    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_in_range) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-edge write to this bank is not visible until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= w_rd_in_range ? r_mem[rd_addr] : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : led_frame_buffer
//  Description : Double-buffered LED pixel store; host fills the back bank,
//                commit swaps banks at the next start of frame.
//  Revision    : 1.0
// ============================================================================
module led_frame_buffer
    import led_frame_buffer_pkg::*;
#(
    parameter  int NUM_LEDS = 6,
    localparam int AW       = clog2_min1(NUM_LEDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_red,
    input  logic [7:0]    wr_green,
    input  logic [7:0]    wr_blue,
    input  logic          commit,
    output logic          commit_pending,
    output logic          wr_error,
    output logic          frame_start,
    input  logic          data_request,
    input  logic [AW-1:0] address,
    output logic [7:0]    red_out,
    output logic [7:0]    green_out,
    output logic [7:0]    blue_out
);

    localparam logic [AW:0]   c_num_leds = (AW+1)'(NUM_LEDS);
    localparam logic [AW-1:0] c_last     = AW'(NUM_LEDS - 1);

    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic          r_fsel;
    logic          r_wr_ready;
    logic          r_commit_pending;
    logic          r_wr_error;
    logic          r_rd_bank;
    logic          r_rd_zero;

    logic               w_wr_fire;
    logic               w_wr_in_range;
    logic               w_rd_in_range;
    logic               w_frame_req;
    logic               w_swap;
    logic               w_front_next;
    logic [1:0]         w_we;
    logic [AW-1:0]      w_waddr;
    logic [PIXEL_W-1:0] w_wdata;
    logic [PIXEL_W-1:0] w_rd_data [2];

    assign w_wr_fire     = wr_valid && r_wr_ready;
    assign w_wr_in_range = ({1'b0, wr_addr} < c_num_leds);
    assign w_rd_in_range = ({1'b0, address} < c_num_leds);
    assign w_frame_req   = data_request && (address == '0);
    assign w_swap        = (r_state == ST_PENDING) && w_frame_req;
    // The swapping request is already served from the bank that becomes front
    assign w_front_next  = r_fsel ^ w_swap;

    always_comb begin
        w_we    = 2'b00;
        w_waddr = wr_addr;
        w_wdata = {wr_red, wr_green, wr_blue};
        if (r_state == ST_CLEAR) begin
            w_we    = 2'b11;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end else if (w_wr_fire && w_wr_in_range) begin
            w_we[~r_fsel] = 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        led_bank_ram #(
            .DEPTH (NUM_LEDS),
            .AW    (AW),
            .DW    (PIXEL_W)
        ) u_ram (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (w_we[b]),
            .wr_addr (w_waddr),
            .wr_data (w_wdata),
            .rd_en   (data_request),
            .rd_addr (address),
            .rd_data (w_rd_data[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_CLEAR;
            r_clr_addr       <= '0;
            r_fsel           <= 1'b0;
            r_wr_ready       <= 1'b0;
            r_commit_pending <= 1'b0;
            r_wr_error       <= 1'b0;
            r_rd_bank        <= 1'b0;
            r_rd_zero        <= 1'b1;
        end else begin
            if (data_request) begin
                r_rd_bank <= w_front_next;
                r_rd_zero <= !w_rd_in_range || (r_state == ST_CLEAR);
            end
            if (w_wr_fire && !w_wr_in_range) begin
                r_wr_error <= 1'b1;
            end
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_last) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_IDLE;
                        r_wr_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (commit) begin
                        r_state          <= ST_PENDING;
                        r_wr_ready       <= 1'b0;
                        r_commit_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_frame_req) begin
                        r_fsel           <= ~r_fsel;
                        r_state          <= ST_IDLE;
                        r_wr_ready       <= 1'b1;
                        r_commit_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= ST_CLEAR;
                    r_clr_addr       <= '0;
                    r_wr_ready       <= 1'b0;
                    r_commit_pending <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready       = r_wr_ready;
    assign commit_pending = r_commit_pending;
    assign wr_error       = r_wr_error;
    assign frame_start    = !reset && w_frame_req;

    assign {red_out, green_out, blue_out} = r_rd_zero ? '0 : w_rd_data[r_rd_bank];

endmodule
`default_nettype wire

// File: tb/tb_led_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_frame_buffer
//  Description : Scoreboard bench for led_frame_buffer against a bank-level model.
//  Revision    : 1.0
// ============================================================================
module tb_led_frame_buffer;

    localparam int N  = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_red = '0, wr_green = '0, wr_blue = '0;
    logic          commit = 1'b0;
    logic          commit_pending;
    logic          wr_error;
    logic          frame_start;
    logic          data_request = 1'b0;
    logic [AW-1:0] address = '0;
    logic [7:0]    red_out, green_out, blue_out;

    led_frame_buffer #(.NUM_LEDS(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_red         (wr_red),
        .wr_green       (wr_green),
        .wr_blue        (wr_blue),
        .commit         (commit),
        .commit_pending (commit_pending),
        .wr_error       (wr_error),
        .frame_start    (frame_start),
        .data_request   (data_request),
        .address        (address),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two banks of pixels, which one is visible, and the host-side mode
    localparam int M_CLEAR = 0, M_IDLE = 1, M_PENDING = 2;
    logic [23:0] m_bank [2][N];
    int          m_front;
    int          m_mode;
    int          m_clear_left;
    bit          m_err;
    logic [23:0] exp_q [$];

    task automatic model_edge(input bit rs, input bit wv, input int wa, input logic [23:0] wd,
                              input bit cm, input bit dr, input int ad);
        int shown;
        if (rs) begin
            m_mode = M_CLEAR;
            m_clear_left = N;
            m_front = 0;
            m_err = 0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < N; i++) m_bank[b][i] = 24'h0;
            return;
        end
        if (dr) begin
            shown = m_front;
            if (m_mode == M_PENDING && ad == 0) shown = 1 - m_front;
            if (m_mode == M_CLEAR || ad >= N) exp_q.push_back(24'h0);
            else exp_q.push_back(m_bank[shown][ad]);
        end
        if (m_mode == M_IDLE && wv) begin
            if (wa < N) m_bank[1 - m_front][wa] = wd;
            else m_err = 1;
        end
        case (m_mode)
            M_CLEAR: begin
                m_clear_left--;
                if (m_clear_left == 0) m_mode = M_IDLE;
            end
            M_IDLE: if (cm) m_mode = M_PENDING;
            default: if (dr && ad == 0) begin
                m_front = 1 - m_front;
                m_mode = M_IDLE;
            end
        endcase
    endtask

    // Called just after a falling edge; drives one cycle and checks the control outputs.
    task automatic tick(input bit rs, input bit wv, input int wa, input logic [23:0] wd,
                        input bit cm, input bit dr, input int ad);
        reset = rs;
        wr_valid = wv;
        wr_addr = AW'(wa);
        {wr_red, wr_green, wr_blue} = wd;
        commit = cm;
        data_request = dr;
        address = AW'(ad);
        #1;
        check("frame_start", {31'b0, frame_start}, {31'b0, (!rs && dr && ad == 0)});
        model_edge(rs, wv, wa, wd, cm, dr, ad);
        @(posedge clk);
        @(negedge clk);
        check("wr_ready", {31'b0, wr_ready}, {31'b0, (m_mode == M_IDLE)});
        check("commit_pending", {31'b0, commit_pending}, {31'b0, (m_mode == M_PENDING)});
        check("wr_error", {31'b0, wr_error}, {31'b0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int a, input logic [23:0] d);
        tick(0, 1, a, d, 0, 0, 0);
    endtask
    task automatic rd(input int a);
        tick(0, 0, 0, 0, 0, 1, a);
    endtask

    // Monitor: the held pixel output must track the most recent requested read.
    logic [23:0] cur_exp = 24'h0;
    bit          cur_valid = 0;
    initial begin
        bit s_rst, s_req;
        forever begin
            @(posedge clk);
            s_rst = reset;
            s_req = data_request;
            @(negedge clk);
            if (s_rst) begin
                cur_exp = 24'h0;
                cur_valid = 1;
            end else if (s_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: read with no expected entry at %0t", $time);
                end else begin
                    cur_exp = exp_q.pop_front();
                end
            end
            if (cur_valid)
                check("pixel", {8'h0, red_out, green_out, blue_out}, {8'h0, cur_exp});
        end
    end

    initial begin
        // Reset and clear sweep; wr_ready is checked each cycle against the countdown
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 1, 0);
        idle(N + 1);
        for (int a = 0; a < N; a++) rd(a);

        // Fill back bank with LED2 = 11/22/33, swap at next frame, read LED2
        for (int a = 0; a < N; a++) wr(a, (a == 2) ? 24'h112233 : 24'h0);
        tick(0, 0, 0, 0, 1, 0, 0);
        rd(0);
        rd(2);
        idle(1);
        check("led2_after_swap", {8'h0, red_out, green_out, blue_out}, 32'h00112233);

        // Commit during a mid-frame read: no swap until address 0
        for (int a = 0; a < N; a++) wr(a, 24'hA00000 | 24'(a));
        tick(0, 0, 0, 0, 1, 1, 3);
        rd(4);
        wr(1, 24'hDEAD01);
        rd(0);
        rd(1);
        rd(5);

        // Out-of-range writes: flag set, no bank change, flag sticky
        wr(7, 24'h777777);
        wr(6, 24'h666666);
        idle(3);
        tick(0, 0, 0, 0, 1, 0, 0);
        rd(0);
        for (int a = 0; a < 8; a++) rd(a);

        // Same-cycle write to LED5 and commit
        for (int a = 0; a < 5; a++) wr(a, 24'h010101 * 24'(a + 1));
        tick(0, 1, 5, 24'h5A5A5A, 1, 0, 0);
        rd(0);
        rd(5);
        idle(1);
        check("led5_same_cycle_commit", {8'h0, red_out, green_out, blue_out}, 32'h005A5A5A);

        // Reset while pending, then reset mid-clear
        wr(3, 24'h333333);
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        rd(3);
        idle(N);
        for (int a = 0; a < N; a++) rd(a);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 $urandom_range(0, 1),
                 $urandom_range(0, 7),
                 24'($urandom),
                 ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7));
        end
        idle(2);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
